// File: rtl/ap_prof_pkg.sv
// Shared types for the ap_ctrl_hs transaction profiler: FSM states and the
// default-width timing record.
package ap_prof_pkg;

  localparam int PROF_CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } prof_state_e;

  typedef struct packed {
    logic [PROF_CNT_W_DEF-1:0] t0;
    logic [PROF_CNT_W_DEF-1:0] latency;
    logic [PROF_CNT_W_DEF-1:0] interval;
  } prof_rec_t;

endpackage

// File: rtl/prof_rec_fifo.sv
// Synchronous record FIFO with wrap-bit pointers. A push on full is accepted
// when a pop happens in the same cycle; the head reads as zero while empty.
module prof_rec_fifo
  import ap_prof_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type rec_t = prof_rec_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  rec_t wr_data,
  input  logic pop,
  output rec_t rd_data,
  output logic full,
  output logic empty,
  output logic overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  rec_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are never visible
  // because the read port is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ap_txn_profiler.sv
// Passive ap_ctrl_hs observer: timestamps each start/done pair and queues
// {t0, latency, interval} records for a valid/ready reader.
module ap_txn_profiler
  import ap_prof_pkg::*;
#(
  parameter int CNT_W  = PROF_CNT_W_DEF,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              finish,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [CNT_W-1:0]  rec_t0,
  output logic [CNT_W-1:0]  rec_latency,
  output logic [CNT_W-1:0]  rec_interval,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              proto_err,
  output logic              busy,
  output logic              drained
);

  typedef struct packed {
    logic [CNT_W-1:0] t0;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] interval;
  } rec_t;

  prof_state_e      state, state_nxt;
  logic [CNT_W-1:0] ts, t0, prev_t0;
  logic             have_prev, ready_seen, finish_lat;
  logic             capture, emit, err;
  rec_t             rec_new, rec_head;
  logic             fifo_full, fifo_empty, overflow, pop;

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    emit      = 1'b0;
    err       = 1'b0;
    rec_new   = '0;
    case (state)
      IDLE: begin
        if (ap_start && !finish_lat) begin
          capture = 1'b1;
          if (ap_done) begin
            emit             = 1'b1;
            rec_new.t0       = ts;
            rec_new.interval = have_prev ? ts - prev_t0 : '0;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          err = ap_done && !ap_start;
          if (finish_lat) state_nxt = FLUSH;
        end
      end
      RUN: begin
        // A start that falls before any ready was observed breaks ap_ctrl_hs.
        err = !ap_start && !ready_seen && !ap_ready;
        if (ap_done) begin
          emit             = 1'b1;
          rec_new.t0       = t0;
          rec_new.latency  = ts - t0;
          rec_new.interval = have_prev ? t0 - prev_t0 : '0;
          state_nxt        = IDLE;
        end
      end
      FLUSH:   state_nxt = FLUSH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ts         <= '0;
      t0         <= '0;
      prev_t0    <= '0;
      have_prev  <= 1'b0;
      ready_seen <= 1'b0;
      finish_lat <= 1'b0;
      txn_cnt    <= '0;
      drop_cnt   <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ts         <= ts + 1'b1;
      finish_lat <= finish_lat | finish;
      if (err) proto_err <= 1'b1;
      if (capture) begin
        t0         <= ts;
        ready_seen <= ap_ready;
      end else if (state == RUN && ap_ready) begin
        ready_seen <= 1'b1;
      end
      if (emit) begin
        prev_t0   <= rec_new.t0;
        have_prev <= 1'b1;
        txn_cnt   <= txn_cnt + 1'b1;
      end
      if (overflow && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  prof_rec_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (emit),
    .wr_data  (rec_new),
    .pop      (pop),
    .rd_data  (rec_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign rec_valid    = !fifo_empty;
  assign pop          = rec_valid && rec_ready;
  assign rec_t0       = rec_head.t0;
  assign rec_latency  = rec_head.latency;
  assign rec_interval = rec_head.interval;
  assign busy         = (state == RUN);
  assign drained      = (state == FLUSH) && fifo_empty;

endmodule

// File: tb/tb_ap_txn_profiler.sv
// Directed bench for ap_txn_profiler: a default-width instance for the main
// flow and an 8-bit instance for timestamp wrap and mid-run reset.
module tb_ap_txn_profiler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 0, ap_ready = 0, ap_done = 0, finish = 0, rec_ready = 0;
  logic        rec_valid, proto_err, busy, drained;
  logic [31:0] rec_t0, rec_latency, rec_interval, txn_cnt;
  logic [15:0] drop_cnt;

  logic        s_reset = 1'b1;
  logic        s_start = 0, s_ready = 0, s_done = 0, s_finish = 0, s_rec_ready = 0;
  logic        s_rec_valid, s_proto_err, s_busy, s_drained;
  logic [7:0]  s_t0, s_latency, s_interval, s_txn_cnt;
  logic [3:0]  s_drop_cnt;

  int          cyc;
  logic [7:0]  s_cyc;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clock = ~clock;

  // Reference timestamps for each instance.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
    if (s_reset) s_cyc <= 8'd0;
    else         s_cyc <= s_cyc + 8'd1;
  end

  ap_txn_profiler dut (
    .clock        (clock),
    .reset        (reset),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .finish       (finish),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_t0       (rec_t0),
    .rec_latency  (rec_latency),
    .rec_interval (rec_interval),
    .txn_cnt      (txn_cnt),
    .drop_cnt     (drop_cnt),
    .proto_err    (proto_err),
    .busy         (busy),
    .drained      (drained)
  );

  ap_txn_profiler #(.CNT_W(8), .DEPTH(4), .DROP_W(4)) dut_small (
    .clock        (clock),
    .reset        (s_reset),
    .ap_start     (s_start),
    .ap_ready     (s_ready),
    .ap_done      (s_done),
    .finish       (s_finish),
    .rec_valid    (s_rec_valid),
    .rec_ready    (s_rec_ready),
    .rec_t0       (s_t0),
    .rec_latency  (s_latency),
    .rec_interval (s_interval),
    .txn_cnt      (s_txn_cnt),
    .drop_cnt     (s_drop_cnt),
    .proto_err    (s_proto_err),
    .busy         (s_busy),
    .drained      (s_drained)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic check_rec(input string tag, input int t0, input int lat, input int intv);
    check({tag, ".valid"},    rec_valid,    1);
    check({tag, ".t0"},       rec_t0,       t0);
    check({tag, ".latency"},  rec_latency,  lat);
    check({tag, ".interval"}, rec_interval, intv);
  endtask

  // Advance on falling edges until the main timestamp reaches n.
  task automatic wait_ts(input int n);
    int k = 0;
    while (cyc != n && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (cyc != n) begin
      n_checks++;
      $display("FAIL wait_ts: timestamp %0d never reached %0d", cyc, n);
    end
  endtask

  task automatic wait_sts(input int n);
    int k = 0;
    while (int'(s_cyc) != n && k < 600) begin
      @(negedge clock);
      k++;
    end
    if (int'(s_cyc) != n) begin
      n_checks++;
      $display("FAIL wait_sts: timestamp %0d never reached %0d", s_cyc, n);
    end
  endtask

  task automatic idle_inputs();
    ap_start = 0;
    ap_ready = 0;
    ap_done  = 0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst.rec_valid", rec_valid, 0);
    check("rst.rec_t0",    rec_t0,    0);
    check("rst.txn_cnt",   txn_cnt,   0);
    check("rst.drop_cnt",  drop_cnt,  0);
    check("rst.proto_err", proto_err, 0);
    check("rst.busy",      busy,      0);
    check("rst.drained",   drained,   0);
    reset   = 0;
    s_reset = 0;

    // First transaction: start at 5, ready+done at 12.
    wait_ts(5);  ap_start = 1;
    wait_ts(12);
    check("t1.busy",       busy,      1);
    check("t1.valid_pre",  rec_valid, 0);
    ap_ready = 1; ap_done = 1;
    wait_ts(13); idle_inputs();
    check_rec("t1", 5, 7, 0);
    check("t1.txn_cnt", txn_cnt, 1);
    check("t1.busy_post", busy, 0);
    rec_ready = 1;
    wait_ts(14); rec_ready = 0;
    check("t1.popped", rec_valid, 0);

    // Start 20, ready 21, done 23; then zero-latency at 30.
    wait_ts(20); ap_start = 1;
    wait_ts(21); ap_ready = 1;
    wait_ts(22); idle_inputs();
    wait_ts(23); ap_done = 1;
    wait_ts(24); idle_inputs();
    wait_ts(30); ap_start = 1; ap_ready = 1; ap_done = 1;
    wait_ts(31); idle_inputs();
    check_rec("t2", 20, 3, 15);
    check("t2.txn_cnt", txn_cnt, 3);
    rec_ready = 1;
    wait_ts(32);
    check_rec("t3", 30, 0, 10);
    wait_ts(33); rec_ready = 0;
    check("t3.popped",   rec_valid, 0);
    check("t3.proto_ok", proto_err, 0);

    // 18 back-to-back transactions with the reader stalled.
    for (int k = 0; k < 18; k++) begin
      wait_ts(40 + 4*k); ap_start = 1; ap_ready = 1;
      wait_ts(41 + 4*k); idle_inputs();
      wait_ts(42 + 4*k); ap_done = 1;
      wait_ts(43 + 4*k); ap_done = 0;
    end
    wait_ts(112);
    check("ovf.drop_cnt", drop_cnt, 2);
    check("ovf.txn_cnt",  txn_cnt,  21);
    rec_ready = 1;
    for (int k = 0; k < 16; k++) begin
      check_rec($sformatf("ovf[%0d]", k), 40 + 4*k, 2, (k == 0) ? 10 : 4);
      @(negedge clock);
    end
    rec_ready = 0;
    check("ovf.empty", rec_valid, 0);

    // Done without start, then start dropped before ready.
    wait_ts(130); ap_done = 1;
    wait_ts(131); ap_done = 0;
    wait_ts(132);
    check("perr.flag",    proto_err, 1);
    check("perr.norec",   rec_valid, 0);
    check("perr.txn_cnt", txn_cnt,   21);
    wait_ts(135); ap_start = 1;
    wait_ts(136); ap_start = 0;
    wait_ts(138); ap_ready = 1; ap_done = 1;
    wait_ts(139); idle_inputs();
    check_rec("perr2", 135, 3, 27);
    check("perr2.txn_cnt", txn_cnt,   22);
    check("perr2.sticky",  proto_err, 1);
    rec_ready = 1;
    wait_ts(140); rec_ready = 0;

    // Finish during RUN; later starts are ignored once flushed.
    wait_ts(150); ap_start = 1;
    wait_ts(151); ap_ready = 1;
    wait_ts(152); idle_inputs(); finish = 1;
    wait_ts(153); finish = 0;
    check("fin.busy", busy, 1);
    wait_ts(155); ap_done = 1;
    wait_ts(156); ap_done = 0;
    wait_ts(160); ap_start = 1; ap_ready = 1; ap_done = 1;
    wait_ts(161); idle_inputs();
    wait_ts(162);
    check_rec("fin", 150, 5, 15);
    check("fin.txn_cnt",   txn_cnt, 23);
    check("fin.not_drain", drained, 0);
    rec_ready = 1;
    wait_ts(163); rec_ready = 0;
    check("fin.drained", drained,   1);
    check("fin.empty",   rec_valid, 0);

    // Reset with a queued record and a transaction in flight.
    reset = 1;
    @(negedge clock);
    reset = 0;
    wait_ts(5);  ap_start = 1; ap_ready = 1; ap_done = 1;
    wait_ts(6);  idle_inputs();
    wait_ts(8);  ap_start = 1;
    wait_ts(10);
    check("mrst.busy_pre",  busy,      1);
    check("mrst.valid_pre", rec_valid, 1);
    reset = 1;
    @(negedge clock);
    reset = 0; idle_inputs();
    check("mrst.rec_valid", rec_valid,   0);
    check("mrst.rec_t0",    rec_t0,      0);
    check("mrst.latency",   rec_latency, 0);
    check("mrst.txn_cnt",   txn_cnt,     0);
    check("mrst.busy",      busy,        0);
    check("mrst.proto_err", proto_err,   0);
    check("mrst.drained",   drained,     0);

    // 8-bit instance: timestamp wrap, early start drop, mid-run reset.
    wait_sts(250); s_start = 1; s_ready = 1;
    wait_sts(251); s_start = 0; s_ready = 0;
    wait_sts(3);   s_done = 1;
    wait_sts(4);   s_done = 0;
    check("wrap.valid",    s_rec_valid, 1);
    check("wrap.t0",       s_t0,        250);
    check("wrap.latency",  s_latency,   9);
    check("wrap.interval", s_interval,  0);
    check("wrap.txn_cnt",  s_txn_cnt,   1);
    check("wrap.proto_ok", s_proto_err, 0);
    wait_sts(10);  s_start = 1;
    wait_sts(11);  s_start = 0;
    wait_sts(12);
    check("sperr.flag", s_proto_err, 1);
    check("sperr.busy", s_busy,      1);
    s_ready = 1; s_done = 1;
    wait_sts(13);  s_ready = 0; s_done = 0;
    check("sperr.txn_cnt", s_txn_cnt, 2);
    check("sperr.head_t0", s_t0,      250);
    wait_sts(20);  s_start = 1;
    wait_sts(22);
    s_reset = 1;
    @(negedge clock);
    s_reset = 0; s_start = 0;
    check("srst.rec_valid", s_rec_valid, 0);
    check("srst.t0",        s_t0,        0);
    check("srst.txn_cnt",   s_txn_cnt,   0);
    check("srst.drop_cnt",  s_drop_cnt,  0);
    check("srst.busy",      s_busy,      0);
    check("srst.proto_err", s_proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
